// File: rtl/reg_alu_datapath_pkg.sv
// Shared constants for the 16-bit multi-cycle CPU datapath: ALU operation
// codes and the CPU opcode map that the control FSM decodes.
package reg_alu_datapath_pkg;

  // ALU operation select (alu_op)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_MUL = 3'd2;
  localparam logic [2:0] ALU_DIV = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;
  localparam logic [2:0] ALU_NOT = 3'd7;

  // CPU instruction opcodes (4-bit field of the instruction register)
  localparam logic [3:0] OP_MOV  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_IN   = 4'd7;
  localparam logic [3:0] OP_OUT  = 4'd8;
  localparam logic [3:0] OP_STOP = 4'd15;

  // Arithmetic opcodes map onto the ALU as opcode[2:0]-1 (ADD..DIV -> 0..3).
  function automatic logic [2:0] opcode_to_alu_op(input logic [3:0] opcode);
    logic [2:0] low;
    low = opcode[2:0];
    return low - 3'd1;
  endfunction

endpackage

// File: rtl/reg_alu_datapath_alu_core.sv
// Combinational unsigned ALU. Every result is truncated to W bits; divide by
// zero returns all-ones so the CPU sees a defined value instead of X.
module alu_core
  import reg_alu_datapath_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] f_o
);

  // Operation decode; products and sums are evaluated at W bits so the
  // carry / high half is dropped naturally.
  always_comb begin
    f_o = '0;
    case (op_i)
      ALU_ADD: f_o = a_i + b_i;
      ALU_SUB: f_o = a_i - b_i;
      ALU_MUL: f_o = a_i * b_i;
      ALU_DIV: f_o = (b_i == '0) ? '1 : (a_i / b_i);
      ALU_AND: f_o = a_i & b_i;
      ALU_OR:  f_o = a_i | b_i;
      ALU_XOR: f_o = a_i ^ b_i;
      ALU_NOT: f_o = ~a_i;
      default: f_o = '0;
    endcase
  end

endmodule

// File: rtl/reg_alu_datapath_gp_register.sv
// General-purpose register used for ACC/PC/SP/IR. One action per clock edge
// with fixed priority clear > load > inc > dec > shift right > shift left;
// with no control asserted the value holds.
module gp_register #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cl_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         sr_i,
  input  logic         ir_i,
  input  logic         sl_i,
  input  logic         il_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next-value selection in priority order; inc/dec wrap modulo 2^W.
  always_comb begin
    q_d = q_q;
    if (cl_i)       q_d = '0;
    else if (ld_i)  q_d = d_i;
    else if (inc_i) q_d = q_q + 1'b1;
    else if (dec_i) q_d = q_q - 1'b1;
    else if (sr_i)  q_d = {ir_i, q_q[W-1:1]};
    else if (sl_i)  q_d = {q_q[W-2:0], il_i};
  end

  // State register; reset clears immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_alu_datapath.sv
// Datapath slice: one general-purpose register plus a combinational ALU.
// The only glue here is the load-source mux, which lets the register take
// the ALU result in the same cycle (acc <= acc op mem).
module reg_alu_datapath
  import reg_alu_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cl,
  input  logic                  ld,
  input  logic                  ld_sel,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  sr,
  input  logic                  ir,
  input  logic                  sl,
  input  logic                  il,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_a,
  input  logic [DATA_WIDTH-1:0] alu_b,
  output logic [DATA_WIDTH-1:0] out,
  output logic [DATA_WIDTH-1:0] alu_f
);

  logic [DATA_WIDTH-1:0] ld_data;

  alu_core #(.W(DATA_WIDTH)) u_alu (
    .op_i (alu_op),
    .a_i  (alu_a),
    .b_i  (alu_b),
    .f_o  (alu_f)
  );

  // Load source: external bus or the ALU result of this cycle.
  always_comb begin
    ld_data = ld_sel ? alu_f : in;
  end

  gp_register #(.W(DATA_WIDTH)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .cl_i  (cl),
    .ld_i  (ld),
    .d_i   (ld_data),
    .inc_i (inc),
    .dec_i (dec),
    .sr_i  (sr),
    .ir_i  (ir),
    .sl_i  (sl),
    .il_i  (il),
    .q_o   (out)
  );

endmodule

// File: tb/tb_reg_alu_datapath.sv
// Directed bench for reg_alu_datapath: register priority, wrap, shifts,
// asynchronous reset, ALU operations and ALU-to-register accumulation.
module tb_reg_alu_datapath;
  import reg_alu_datapath_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         cl, ld, ld_sel, inc, dec, sr, ir, sl, il;
  logic [W-1:0] in;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a, alu_b;
  logic [W-1:0] out, alu_f;

  int checks;
  int failures;
  logic [W-1:0] exp_q[$];

  reg_alu_datapath #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cl     (cl),
    .ld     (ld),
    .ld_sel (ld_sel),
    .inc    (inc),
    .dec    (dec),
    .sr     (sr),
    .ir     (ir),
    .sl     (sl),
    .il     (il),
    .in     (in),
    .alu_op (alu_op),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .out    (out),
    .alu_f  (alu_f)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%04h expected=0x%04h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic clear_ctrl();
    cl = 0; ld = 0; ld_sel = 0; inc = 0; dec = 0;
    sr = 0; ir = 0; sl = 0; il = 0;
  endtask

  // Apply the currently driven controls for one edge, then check out against
  // the next expected register value.
  task automatic edge_and_check(input string tag, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    clear_ctrl();
    check(tag, out, exp_q.pop_front());
  endtask

  task automatic load(input logic [W-1:0] v);
    ld = 1; in = v;
    edge_and_check("load", v);
  endtask

  task automatic alu_check(input string tag, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp);
    alu_op = op; alu_a = a; alu_b = b;
    #1;
    check(tag, alu_f, exp);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear_ctrl();
    in = '0; alu_op = ALU_ADD; alu_a = '0; alu_b = '0;
    rst_n = 0;
    #12;
    check("reset_state", out, 16'h0000);
    rst_n = 1;
    #2;

    // asynchronous reset between edges
    load(16'hBEEF);
    #3;
    rst_n = 0;
    #1;
    check("async_reset", out, 16'h0000);
    #1;
    rst_n = 1;

    // priority
    load(16'h5555);
    cl = 1; ld = 1; inc = 1; in = 16'h1234;
    edge_and_check("prio_cl", 16'h0000);
    ld = 1; inc = 1; in = 16'h1234;
    edge_and_check("prio_ld", 16'h1234);
    inc = 1; dec = 1;
    edge_and_check("prio_inc", 16'h1235);
    dec = 1; sr = 1; ir = 1;
    edge_and_check("prio_dec", 16'h1234);
    sr = 1; sl = 1; il = 1;
    edge_and_check("prio_sr", 16'h091A);
    edge_and_check("hold", 16'h091A);

    // wrap
    load(16'hFFFF);
    inc = 1;
    edge_and_check("inc_wrap", 16'h0000);
    dec = 1;
    edge_and_check("dec_wrap", 16'hFFFF);

    // shifts
    load(16'h8001);
    sr = 1; ir = 1;
    edge_and_check("sr_ir1", 16'hC000);
    sl = 1; il = 0;
    edge_and_check("sl_il0", 16'h8000);
    sl = 1; il = 1;
    edge_and_check("sl_il1", 16'h0001);
    sr = 1; ir = 0;
    edge_and_check("sr_ir0", 16'h0000);

    // ALU
    alu_check("add",      ALU_ADD, 16'd7, 16'd3, 16'd10);
    alu_check("sub",      ALU_SUB, 16'd7, 16'd3, 16'd4);
    alu_check("mul",      ALU_MUL, 16'd7, 16'd3, 16'd21);
    alu_check("div",      ALU_DIV, 16'd7, 16'd3, 16'd2);
    alu_check("sub_neg",  ALU_SUB, 16'd3, 16'd7, 16'hFFFC);
    alu_check("mul_trunc",ALU_MUL, 16'h0100, 16'h0100, 16'h0000);
    alu_check("div_zero", ALU_DIV, 16'd7, 16'd0, 16'hFFFF);
    alu_check("add_carry",ALU_ADD, 16'hFFFF, 16'h0002, 16'h0001);
    alu_check("and",      ALU_AND, 16'hF0F0, 16'hFF00, 16'hF000);
    alu_check("or",       ALU_OR,  16'hF0F0, 16'hFF00, 16'hFFF0);
    alu_check("xor",      ALU_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0);
    alu_check("not",      ALU_NOT, 16'hF0F0, 16'hFF00, 16'h0F0F);
    alu_check("op_map_div", opcode_to_alu_op(OP_DIV), 16'd9, 16'd2, 16'd4);

    // accumulate: acc <= acc * 6
    load(16'd5);
    alu_check("acc_alu", ALU_MUL, out, 16'd6, 16'd30);
    ld = 1; ld_sel = 1; in = 16'h7777;
    edge_and_check("acc_load", 16'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
